uart_tx: RTL

Byte-oriented UART transmitter for the single-cycle SoC. It sits directly downstream of the bus UART port and consumes the `cen`/`wr`/`wdata` byte writes that the CPU issues. Each accepted byte is buffered in a small FIFO and serialised onto `txd` as 8N1 frames, LSB first, at a fixed clock-divided bit rate. The block replaces the simulation-only print sink, so firmware output becomes a real serial waveform that the bench decodes.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the byte-oriented UART
//                transmitter (frame geometry and FSM state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Payload width of one serial character.
    localparam int UART_DATA_W     = 8;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    // Width of the data-bit index inside a frame.
    localparam int UART_BIT_IDX_W  = $clog2(UART_DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with a separately held
//                occupancy count. Pushes into a full FIFO and pops from an
//                empty FIFO are ignored.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   clock, rising edge
//    rst    in   synchronous active-high reset (pointers and count cleared)
//    push   in   write din at the tail
//    pop    in   drop the head entry
//    din    in   WIDTH-bit write data
//    dout   out  WIDTH-bit head entry (valid while empty = 0)
//    full   out  count == DEPTH
//    empty  out  count == 0
//    count  out  registered occupancy, $clog2(DEPTH)+1 bits
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == COUNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop  & ~empty;

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Bus-attached UART transmitter. CPU byte writes are queued in
//                a FIFO and serialised on txd as 8N1 frames, LSB first, at
//                CLK_DIV clock cycles per bit. Reads and writes to a full
//                FIFO are flagged on the combinational error output.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   clock, rising edge
//    rst         in   synchronous active-high reset
//    cen         in   bus access strobe for the UART region
//    wr          in   1 = write, 0 = read
//    wdata       in   byte to transmit
//    error       out  combinational: cen & (~wr | full)
//    txd         out  registered serial line, idles high
//    tx_busy     out  registered: frame on the line or FIFO non-empty
//    fifo_count  out  registered FIFO occupancy
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter  int CLK_DIV    = 16,
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   wr,
    input  logic [UART_DATA_W-1:0] wdata,
    output logic                   error,
    output logic                   txd,
    output logic                   tx_busy,
    output logic [CW-1:0]          fifo_count
);

    localparam int                        BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0]         BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST  = UART_BIT_IDX_W'(UART_DATA_W - 1);

    uart_state_e                state_q;
    logic [BAUD_W-1:0]          baud_q;
    logic [UART_BIT_IDX_W-1:0]  bit_idx_q;
    logic [UART_DATA_W-1:0]     shreg_q;
    logic                       txd_q;
    logic                       tx_busy_q;

    logic                       w_full;
    logic                       w_empty;
    logic [UART_DATA_W-1:0]     w_head;
    logic [CW-1:0]              w_count;
    logic                       w_accept;
    logic                       w_baud_last;
    logic                       w_pop;
    logic [CW-1:0]              w_count_d;
    logic                       w_line_active_d;
    logic                       tx_busy_d;

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    // full comes from the registered count, so a pop in the same cycle does
    // not make room for the incoming byte.
    assign w_accept = cen & wr & ~w_full;
    assign error    = cen & (~wr | w_full);

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (wdata),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // ------------------------------------------------------------------
    // Transmit sequencing
    // ------------------------------------------------------------------
    assign w_baud_last = (baud_q == BAUD_LAST);

    // A byte leaves the FIFO either from IDLE or on the last stop-bit cycle,
    // the latter giving back-to-back frames with no idle gap.
    assign w_pop = ~w_empty &
                   ((state_q == IDLE) | ((state_q == STOP) & w_baud_last));

    // Occupancy and line activity after the coming edge, so tx_busy is
    // registered yet changes on the same edge as the event causing it.
    assign w_count_d       = w_count + CW'(w_accept) - CW'(w_pop);
    assign w_line_active_d = w_pop |
                             ((state_q != IDLE) & ~((state_q == STOP) & w_baud_last));
    assign tx_busy_d       = w_line_active_d | (w_count_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            tx_busy_q <= tx_busy_d;
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                    if (w_pop) begin
                        shreg_q   <= w_head;
                        bit_idx_q <= '0;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end
                end

                START: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        txd_q   <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (w_baud_last) begin
                        baud_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        if (bit_idx_q == BIT_LAST) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + UART_BIT_IDX_W'(1);
                            // Next bit to appear is the one about to shift into bit 0.
                            txd_q     <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (w_baud_last) begin
                        baud_q <= '0;
                        if (w_pop) begin
                            shreg_q   <= w_head;
                            bit_idx_q <= '0;
                            txd_q     <= 1'b0;
                            state_q   <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                default: begin
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = tx_busy_q;
    assign fifo_count = w_count;

endmodule : uart_tx
`default_nettype wire
